rr_bus_arbiter: RTL and testbench
=================================

// Module: rr_bus_arbiter
// PURPOSE
//   Round-robin arbiter that shares one tristate output bus (the uo_out pins) among
//   N_REQ requesters, e.g. several counter blocks. It issues a one-hot grant and the
//   bus output-enable. It caps how long any owner may hold the bus. It inserts
//   turnaround cycles between owners so two drivers never contend.
// PARAMETERS
//   N_REQ        4   number of requesters (2..8)
//   MAX_HOLD     8   max consecutive cycles one grant may stay asserted (>=1)
//   TURN_CYCLES  1   bus-idle cycles between release and next grant (>=1)
// PORTS
//   clk       in   1                 clock; all logic on posedge
//   rst_n     in   1                 reset, synchronous, active-low
//   arb_en    in   1                 1 = new grants allowed
//   req       in   N_REQ             level requests, one bit per requester
//   grant     out  N_REQ             one-hot grant, registered
//   bus_oe    out  1                 tristate enable for the shared bus, registered
//   owner_id  out  $clog2(N_REQ)     binary index of current or last owner
//   busy      out  1                 1 while state != IDLE
// BEHAVIOUR
//   Reset (rst_n==0 sampled at posedge):
//   - grant=0, bus_oe=0, owner_id=0, busy=0.
//   - state=IDLE, hold_cnt=0, rr_ptr=N_REQ-1, so requester 0 has top priority first.
//   - Reset mid-grant: both grant and bus_oe are 0 in the cycle after the reset edge.
//     No turnaround is inserted.
//   Invariant: bus_oe == |grant in every cycle, and grant is never multi-hot.
//   Arbitration (comb): winner = first set bit of req, scanning from rr_ptr+1 upward
//   with wrap modulo N_REQ.
//   FSM:
//   - IDLE: if arb_en && |req, then on the next edge grant<=onehot(winner),
//     bus_oe<=1, owner_id<=winner, hold_cnt<=1, and go to GRANT.
//     Latency is 1 cycle from sampled req to visible grant.
//   - GRANT: release when req[owner_id]==0, or when hold_cnt==MAX_HOLD.
//     On release, at the next edge: grant<=0, bus_oe<=0, rr_ptr<=owner_id,
//     turn_cnt<=1, go to TURN. Otherwise hold_cnt++.
//     So grant is visible for at most MAX_HOLD cycles.
//     arb_en has no effect on a grant already issued.
//   - TURN: grant=0. If turn_cnt<TURN_CYCLES, increment it.
//     On the last turnaround cycle, arbitrate as in IDLE. If a winner exists, go
//     straight to GRANT; otherwise go to IDLE.
//     The bus is therefore undriven for exactly TURN_CYCLES cycles between owners.
//   Fairness:
//   - An owner cut off at MAX_HOLD becomes lowest priority.
//   - If it is the only requester, it is re-granted after TURN_CYCLES.
//   Simultaneous events:
//   - req[owner] drops in the same cycle hold_cnt==MAX_HOLD: a single release.
//   - Requests arriving during TURN are visible to the last-cycle arbitration.
//   - A req pulse of 1 cycle in IDLE yields a 1-cycle grant. The release is seen in
//     GRANT when req is already low.
//   owner_id holds the last owner while in IDLE/TURN.
//   busy=1 in GRANT and TURN.
// TESTING (N_REQ=4, MAX_HOLD=8, TURN_CYCLES=1)
//   1. rst_n=0 for 2 cycles with req=4'b1111 -> grant=0, bus_oe=0, owner_id=0.
//      After rst_n=1, grant=4'b0001 exactly 1 cycle later.
//   2. req[2]=1 in cycles 0-2 only -> grant=4'b0100 and bus_oe=1 in cycles 1-3,
//      then 0 in cycle 4. busy=0 from cycle 6.
//   3. req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001, each asserted
//      8 cycles with exactly 1 idle cycle between them.
//   4. req=4'b0001 held -> 8 cycles granted, 1 cycle grant=0 and bus_oe=0, then
//      re-granted. bus_oe never differs from |grant.
//   5. arb_en=0 asserted mid-grant -> current grant runs to release, then no grant
//      while arb_en=0. After arb_en=1, grant follows within 1 cycle.
//   6. rst_n=0 pulsed while grant=4'b0100 -> grant=0 the next cycle.
//      Then with req=4'b0101, 4'b0001 wins first (rr_ptr restored).

Source files
------------

// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_bus_arbiter
// Purpose  : Round-robin arbiter that shares one tristate bus among N_REQ
//            requesters. It issues a registered one-hot grant and a matching
//            output-enable, caps each tenure at MAX_HOLD cycles, and leaves
//            the bus undriven for TURN_CYCLES cycles between owners.
// Revision : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic                     bus_oe,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam int TW  = $clog2(TURN_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  logic [1:0]       state;
  logic [HW-1:0]    hold_cnt;
  logic [TW-1:0]    turn_cnt;
  logic [IDW-1:0]   rr_ptr;

  logic             win_valid;
  logic [IDW-1:0]   win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [IDW:0]     scan_sum;
  logic [IDW-1:0]   scan_idx;
  logic             take;
  logic             release_now;

  // Rotating priority scan: walk from farthest to nearest so the requester
  // closest after rr_ptr (with wrap) is the last one written and wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (scan_sum >= (IDW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (IDW+1)'(N_REQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Grant decision and release decision for the current cycle.
  always_comb begin
    win_onehot  = N_REQ'(1) << win_idx;
    take        = arb_en && win_valid;
    release_now = !req[owner_id] || (hold_cnt == HW'(MAX_HOLD));
  end

  // Arbiter FSM: issue grants, enforce the hold cap, and insert turnaround.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      bus_oe   <= 1'b0;
      owner_id <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      rr_ptr   <= IDW'(N_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            grant    <= win_onehot;
            bus_oe   <= 1'b1;
            owner_id <= win_idx;
            hold_cnt <= HW'(1);
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            grant    <= '0;
            bus_oe   <= 1'b0;
            rr_ptr   <= owner_id;
            turn_cnt <= TW'(1);
            state    <= S_TURN;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_TURN: begin
          if (turn_cnt < TW'(TURN_CYCLES)) begin
            turn_cnt <= turn_cnt + TW'(1);
          end else if (take) begin
            grant    <= win_onehot;
            bus_oe   <= 1'b1;
            owner_id <= win_idx;
            hold_cnt <= HW'(1);
            state    <= S_GRANT;
          end else begin
            state    <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          grant  <= '0;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_bus_arbiter
// Purpose  : Directed bench for rr_bus_arbiter (N_REQ=4, MAX_HOLD=8,
//            TURN_CYCLES=1) with a tenure-level reference model and
//            hand-computed grant expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_bus_arbiter;

  localparam int N   = 4;
  localparam int MH  = 8;
  localparam int TC  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arb_en;
  logic [3:0] req;
  logic [3:0] grant;
  logic       bus_oe;
  logic [1:0] owner_id;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  rr_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req),
    .grant(grant), .bus_oe(bus_oe), .owner_id(owner_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the current tenure (owner, cycles used) and
  // the remaining bus-idle cycles; priority rotates past the last owner.
  bit m_on      = 1'b0;
  int m_owner   = 0;
  int m_used    = 0;
  int m_idle    = 0;
  int m_last    = N - 1;

  function automatic logic [3:0] m_grant();
    return m_on ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  task automatic m_try_grant();
    if (arb_en) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req[c]) begin
          m_on    = 1'b1;
          m_owner = c;
          m_used  = 1;
          break;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1'b0; m_owner = 0; m_used = 0; m_idle = 0; m_last = N - 1;
    end else if (m_on) begin
      if (!req[m_owner] || m_used == MH) begin
        m_on   = 1'b0;
        m_last = m_owner;
        m_idle = TC;
      end else begin
        m_used++;
      end
    end else if (m_idle > 0) begin
      m_idle--;
      if (m_idle == 0) m_try_grant();
    end else begin
      m_try_grant();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("model_grant",  32'(grant),    32'(m_grant()));
      chk("model_bus_oe", 32'(bus_oe),   32'(m_on));
      chk("model_owner",  32'(owner_id), 32'(m_owner));
      chk("model_busy",   32'(busy),     32'(m_on || (m_idle > 0)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic expect_grant(input string name, input logic [3:0] lit);
    chk(name, 32'(grant), 32'(lit));
    chk({name, "_model"}, 32'(m_grant()), 32'(lit));
  endtask

  initial begin
    rst_n  = 1'b0;
    arb_en = 1'b1;
    req    = 4'b1111;

    // 1: reset with all requests pending
    tick();
    mon_on = 1'b1;
    tick();
    expect_grant("rst_grant", 4'b0000);
    chk("rst_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_owner", 32'(owner_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    expect_grant("first_grant", 4'b0001);

    // 3: all requesting -> 8-cycle tenures, 1 idle cycle, rotating
    for (int t = 2; t <= 37; t++) begin
      logic [3:0] e;
      tick();
      e = (t % 9 == 0) ? 4'b0000 : (4'b0001 << ((t / 9) % 4));
      expect_grant($sformatf("rr_t%0d", t), e);
    end

    // 4: single requester is cut off and re-granted
    req = 4'b0000;
    repeat (4) tick();
    req = 4'b0001;
    for (int t = 1; t <= 19; t++) begin
      tick();
      expect_grant($sformatf("solo_t%0d", t), (t % 9 == 0) ? 4'b0000 : 4'b0001);
    end
    req = 4'b0000;
    repeat (4) tick();

    // 2: 3-cycle request pulse on requester 2
    req = 4'b0100;
    tick();
    expect_grant("pulse_c1", 4'b0100);
    tick();
    tick();
    expect_grant("pulse_c3", 4'b0100);
    chk("pulse_c3_oe", 32'(bus_oe), 32'd1);
    req = 4'b0000;
    tick();
    expect_grant("pulse_c4", 4'b0000);
    chk("pulse_c4_oe", 32'(bus_oe), 32'd0);
    tick();
    tick();
    chk("pulse_c6_busy", 32'(busy), 32'd0);
    repeat (2) tick();

    // 5: arb_en dropped mid-grant
    req = 4'b0010;
    tick();
    expect_grant("en_t1", 4'b0010);
    tick();
    tick();
    arb_en = 1'b0;
    req    = 4'b1010;
    for (int t = 4; t <= 14; t++) begin
      tick();
      expect_grant($sformatf("en_t%0d", t), (t <= 8) ? 4'b0010 : 4'b0000);
    end
    arb_en = 1'b1;
    tick();
    expect_grant("en_resume", 4'b1000);

    // 6: reset while requester 2 owns the bus
    req = 4'b0100;
    tick();
    expect_grant("pre_rst_turn", 4'b0000);
    tick();
    expect_grant("pre_rst_own2", 4'b0100);
    rst_n = 1'b0;
    tick();
    expect_grant("midrst_grant", 4'b0000);
    chk("midrst_oe", 32'(bus_oe), 32'd0);
    rst_n = 1'b1;
    req   = 4'b0101;
    tick();
    expect_grant("post_rst_prio", 4'b0001);

    // Mixed traffic checked by the model alone
    for (int t = 0; t < 300; t++) begin
      req    = 4'($urandom_range(0, 15));
      arb_en = ($urandom_range(0, 7) != 0);
      rst_n  = ($urandom_range(0, 63) != 0);
      tick();
    end

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
